// File: rtl/logic_gate_pipe.sv
// Two-stage registered bitwise operation unit with valid/ready handshakes.
// Each result travels with its OR/AND/XOR reductions; ACC_OR and ACC_CLR use an internal sticky register.
module logic_gate_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_any,
  output logic             y_all,
  output logic             y_par
);

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND    = 3'b000;
  localparam logic [OP_W-1:0] OP_OR     = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR    = 3'b010;
  localparam logic [OP_W-1:0] OP_NAND   = 3'b011;
  localparam logic [OP_W-1:0] OP_NOR    = 3'b100;
  localparam logic [OP_W-1:0] OP_XNOR   = 3'b101;
  localparam logic [OP_W-1:0] OP_ACC_OR = 3'b110;

  logic             s1_valid_d, s1_valid_q;
  logic [WIDTH-1:0] s1_y_d,     s1_y_q;
  logic [WIDTH-1:0] acc_d,      acc_q;
  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] y_d,        y_q;
  logic             y_any_d,    y_any_q;
  logic             y_all_d,    y_all_q;
  logic             y_par_d,    y_par_q;

  logic             s2_en;
  logic             s1_en;
  logic             accept;
  logic [WIDTH-1:0] res;

  // Stage enables: a stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    s2_en  = !out_valid_q || out_ready;
    s1_en  = !s1_valid_q || s2_en;
    accept = in_valid && s1_en;
  end

  // Operation decode; every op code is legal, 111 yields zero.
  always_comb begin
    res = '0;
    case (op)
      OP_AND:    res = a & b;
      OP_OR:     res = a | b;
      OP_XOR:    res = a ^ b;
      OP_NAND:   res = ~(a & b);
      OP_NOR:    res = ~(a | b);
      OP_XNOR:   res = ~(a ^ b);
      OP_ACC_OR: res = acc_q | a | b;
      default:   res = '0;
    endcase
  end

  // Next-state: acc updates at acceptance so chained ACC_OR beats see each other.
  always_comb begin
    acc_d       = acc_q;
    s1_valid_d  = s1_valid_q;
    s1_y_d      = s1_y_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    y_any_d     = y_any_q;
    y_all_d     = y_all_q;
    y_par_d     = y_par_q;

    if (accept && op[2] && op[1]) begin
      acc_d = res;
    end

    if (s1_en) begin
      s1_valid_d = in_valid;
    end
    if (accept) begin
      s1_y_d = res;
    end

    if (s2_en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        y_d     = s1_y_q;
        y_any_d = |s1_y_q;
        y_all_d = &s1_y_q;
        y_par_d = ^s1_y_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_y_q      <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      y_any_q     <= 1'b0;
      y_all_q     <= 1'b0;
      y_par_q     <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      s1_valid_q  <= s1_valid_d;
      s1_y_q      <= s1_y_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      y_any_q     <= y_any_d;
      y_all_q     <= y_all_d;
      y_par_q     <= y_par_d;
    end
  end

  assign in_ready  = s1_en;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign y_any     = y_any_q;
  assign y_all     = y_all_q;
  assign y_par     = y_par_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Bench for logic_gate_pipe: directed WIDTH=8 vectors and sequences, plus
// scoreboarded random stress on WIDTH=1 and WIDTH=33 instances.
module tb_logic_gate_pipe;

  logic       clk;
  logic       rst_n;
  logic       rst_s_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       y_any;
  logic       y_all;
  logic       y_par;

  int n_total;
  int n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic_gate_pipe #(.WIDTH(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .y_any     (y_any),
    .y_all     (y_all),
    .y_par     (y_par)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       any;
    logic       all;
    logic       par;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic offer(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    int n;
    n = 0;
    in_valid = 1'b1; op = o; a = x; b = z;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Random stress instances with their own scoreboards.
  for (genvar g = 0; g < 2; g++) begin : g_st
    localparam int unsigned W = (g == 0) ? 1 : 33;
    logic         iv, ir, ov, orr, yany, yall, ypar;
    logic [W-1:0] sa, sb, sy, macc, e, last_y;
    logic [2:0]   sop;
    logic [W-1:0] q [$];
    logic         took, stalled;
    int           npass, ntot;
    bit           done;

    logic_gate_pipe #(.WIDTH(W)) u_st (
      .clk       (clk),
      .rst_n     (rst_s_n),
      .in_valid  (iv),
      .in_ready  (ir),
      .a         (sa),
      .b         (sb),
      .op        (sop),
      .out_valid (ov),
      .out_ready (orr),
      .y         (sy),
      .y_any     (yany),
      .y_all     (yall),
      .y_par     (ypar)
    );

    initial begin
      iv = 1'b0; orr = 1'b0; sa = '0; sb = '0; sop = '0;
      macc = '0; took = 1'b0; stalled = 1'b0; last_y = '0;
      npass = 0; ntot = 0; done = 1'b0;
      repeat (4) @(negedge clk);
      for (int c = 0; c < 10000; c++) begin
        @(negedge clk);
        if (!(iv && !took)) begin
          iv  = ($urandom_range(0, 9) < 7);
          sa  = W'({$urandom, $urandom});
          sb  = W'({$urandom, $urandom});
          sop = 3'($urandom_range(0, 7));
        end
        orr = ($urandom_range(0, 3) != 0);
        #1;
        if (stalled) begin
          ntot++;
          if (sy === last_y && ov === 1'b1) npass++;
          else $display("FAIL stress_w%0d_hold: y %0h expected %0h", W, sy, last_y);
        end
        if (ov && orr) begin
          ntot++;
          if (q.size() == 0) begin
            $display("FAIL stress_w%0d_extra: unexpected beat y %0h", W, sy);
          end else begin
            e = q.pop_front();
            if ({sy, yany, yall, ypar} === {e, |e, &e, ^e}) npass++;
            else $display("FAIL stress_w%0d_beat: got %0h/%b%b%b expected %0h/%b%b%b",
                          W, sy, yany, yall, ypar, e, |e, &e, ^e);
          end
        end
        stalled = ov && !orr;
        last_y  = sy;
        took    = iv && ir;
        if (took) begin
          case (sop)
            3'd0: e = sa & sb;
            3'd1: e = sa | sb;
            3'd2: e = sa ^ sb;
            3'd3: e = ~(sa & sb);
            3'd4: e = ~(sa | sb);
            3'd5: e = ~(sa ^ sb);
            3'd6: begin e = macc | sa | sb; macc = e; end
            default: begin e = '0; macc = '0; end
          endcase
          q.push_back(e);
        end
      end
      done = 1'b1;
    end
  end

  initial begin
    n_total = 0; n_pass = 0;
    rst_n = 1'b0; rst_s_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;

    vecs[0]  = '{3'd0, 8'hC5, 8'h3A, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'd1, 8'hC5, 8'h3A, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{3'd2, 8'hC5, 8'h3A, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{3'd3, 8'hC5, 8'h3A, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{3'd4, 8'hC5, 8'h3A, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'd5, 8'hC5, 8'h3A, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'd6, 8'hC5, 8'h3A, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{3'd7, 8'hC5, 8'h3A, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'd7, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'd6, 8'h01, 8'h00, 8'h01, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{3'd6, 8'h10, 8'h02, 8'h13, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{3'd6, 8'h00, 8'h00, 8'h13, 1'b1, 1'b0, 1'b1};

    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_y", 64'(y), 64'd0);
    check("rst_reductions", 64'({y_any, y_all, y_par}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; rst_s_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Op table and accumulate chain, one beat at a time with the consumer ready.
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      offer(vecs[i].op, vecs[i].a, vecs[i].b);
      #1;
      check($sformatf("v%0d_early_valid", i), 64'(out_valid), 64'd0);
      @(negedge clk); #1;
      check($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("v%0d_y", i), 64'(y), 64'(vecs[i].y));
      check($sformatf("v%0d_red", i), 64'({y_any, y_all, y_par}),
            64'({vecs[i].any, vecs[i].all, vecs[i].par}));
      @(negedge clk);
    end

    // Backpressure: two beats fill the pipe, the third must wait.
    out_ready = 1'b0;
    offer(3'd1, 8'h0F, 8'hF0);
    offer(3'd0, 8'hFF, 8'h0F);
    in_valid = 1'b1; op = 3'd2; a = 8'hAA; b = 8'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      check("bp_hold_y", 64'({out_valid, y}), 64'h1FF);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'd1);
    check("bp_out0", 64'({out_valid, y}), 64'h1FF);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("bp_out1", 64'({out_valid, y}), 64'h10F);
    @(negedge clk); #1;
    check("bp_out2", 64'({out_valid, y, y_par}), 64'h3FE);
    @(negedge clk); #1;
    check("bp_drained", 64'(out_valid), 64'd0);
    @(negedge clk);

    // Reset with two ACC_OR beats in flight.
    out_ready = 1'b0;
    offer(3'd6, 8'h01, 8'h00);
    offer(3'd6, 8'h02, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_y", 64'(y), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    offer(3'd6, 8'h04, 8'h00);
    @(negedge clk); #1;
    check("post_rst_acc", 64'({out_valid, y}), 64'h104);
    @(negedge clk);

    for (int i = 0; i < 20000 && !(g_st[0].done && g_st[1].done); i++) @(negedge clk);
    check("stress_done", 64'({g_st[0].done, g_st[1].done}), 64'd3);
    check("stress_w1_drain", 64'(g_st[0].q.size() <= 2), 64'd1);
    check("stress_w33_drain", 64'(g_st[1].q.size() <= 2), 64'd1);

    $display("%0d/%0d checks passed", n_pass + g_st[0].npass + g_st[1].npass,
             n_total + g_st[0].ntot + g_st[1].ntot);
    $finish;
  end

endmodule

// File: doc/logic_gate_pipe.md
# logic_gate_pipe

- Parametrised, registered successor to the team's single-bit two-input gates.
- Applies one of eight selectable bitwise operations to two WIDTH-bit operands: AND, OR, XOR, NAND, NOR, XNOR, sticky OR-accumulate and accumulate-clear.
- Pipeline is two stages deep with valid/ready handshakes on both sides; each result also carries its reductions.
- Sits between an operand source and a downstream consumer in the gate-exercise datapath.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1 to 64.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  operation select, sampled with the beat.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result this cycle.
- y  out  WIDTH  result.
- y_any  out  1  reduction OR of y.
- y_all  out  1  reduction AND of y.
- y_par  out  1  reduction XOR of y (odd parity).

## Operation
- A beat is accepted when in_valid and in_ready are both 1. A result is delivered when out_valid and out_ready are both 1.
- Operation codes:
  - 000 AND: a&b.
  - 001 OR: a|b.
  - 010 XOR: a^b.
  - 011 NAND: ~(a&b).
  - 100 NOR: ~(a|b).
  - 101 XNOR: ~(a^b).
  - 110 ACC_OR: result = acc|a|b, and acc takes the result.
  - 111 ACC_CLR: result = 0, and acc is cleared to 0.
- acc is an internal WIDTH-bit register.
  - It changes only on accepted beats whose op is 110 or 111.
  - Because it updates in stage 1 at acceptance, back-to-back ACC_OR beats chain correctly with no hazard.
- Stage 1 registers the result and its valid bit. Stage 2 is the output register holding y, y_any, y_all, y_par and out_valid.
- The reduction outputs are computed from the stage-1 result and registered with y, so all four outputs always belong to the same beat.
- Stage advance rules:
  - s2_en = !out_valid | out_ready
  - s1_en = !s1_valid | s2_en
  - in_ready = s1_en
- Ready paths are combinational, from out_ready to in_ready. There is no skid buffer.
- Ordering is strictly FIFO. Beats are never dropped or duplicated while rst_n is high.
- While out_valid is 1 and out_ready is 0, y and the reduction outputs hold stable.
- op values are fully decoded; no value is illegal.

## Timing
- Reset (asynchronous assert, synchronous deassert expected from the system):
  - out_valid, s1_valid = 0.
  - y = 0, acc = 0.
  - y_any = 0, y_all = 0, y_par = 0.
  - in_ready = 1 from the first cycle after reset deasserts.
- Latency: a beat accepted at edge N appears on y with out_valid = 1 after edge N+1 and is consumable in cycle N+1.
- Throughput: one beat per cycle while out_ready is held 1.
- Capacity: 2 beats. With out_ready = 0, in_ready falls after two accepts.
- Simultaneous events:
  - Full pipeline with out_ready = 1: the output is consumed, stage 1 moves to stage 2 and a new beat enters, all in the same cycle.
  - in_valid with in_ready = 0: no acceptance and no acc change. The source must hold a, b and op stable.
- Reset mid-operation: in-flight beats are discarded and acc is cleared immediately on rst_n falling. No partial output appears.
- WIDTH = 1: y_any, y_all and y_par all equal y.

## Test plan
- All 8 ops, WIDTH = 8, a = 8'hC5, b = 8'h3A, out_ready = 1 -> y in order:
  - AND 00, OR FF, XOR FF, NAND FF, NOR 00, XNOR 00.
  - ACC_OR FF, ACC_CLR 00.
  - Each beat arrives one cycle after acceptance.
- Accumulate chain:
  - Beats: ACC_CLR; ACC_OR a = 01 b = 00; ACC_OR a = 10 b = 02; ACC_OR a = 00 b = 00.
  - Expected y: 00, 01, 13, 13.
  - Expected y_par: 0, 1, 1, 1.
  - Expected y_any: 0, 1, 1, 1.
- Backpressure:
  - Hold out_ready = 0 and offer 3 beats (OR 0F|F0, AND FF&0F, XOR AA^55).
  - Expected: in_ready = 0 after the 2nd accept, and y holds FF stable.
  - Then release out_ready -> outputs FF, 0F, FF in order with no loss.
- Reductions with y = FF -> y_all = 1, y_any = 1, y_par = 0. With y = 00 -> all three are 0.
- Reset mid-flight:
  - After 2 ACC_OR beats are in the pipe, pulse rst_n low between clock edges.
  - Expected: out_valid drops immediately, y = 00.
  - A following ACC_OR with a = 04, b = 00 -> y = 04, showing acc was cleared.
- Random stress with WIDTH = 1 and WIDTH = 33:
  - Random in_valid, out_ready and op.
  - A scoreboard reference model must match every delivered beat, including acc state, over 10,000 cycles.
